// File: rtl/line_write_ctrl.sv
// Camera line writer: routes accepted pixels into a 6-bank line buffer and flags when 5 lines are held.
// Optional row/frame tracking is enabled by defining LINE_WRITE_CTRL_ROW_COUNT_EN.
module line_write_ctrl #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       write_enable,
  output logic [2:0] select,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       line_done,
  output logic       lines_ready
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
  ,
  output logic [8:0] row_idx,
  output logic       frame_done
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  localparam logic [8:0] LAST_COL = 9'(IMG_WIDTH - 1);

  if (IMG_WIDTH < 2 || IMG_WIDTH > 512 || IMG_HEIGHT < 1) begin : g_param_check
    $error("line_write_ctrl: IMG_WIDTH must be 2..512 and IMG_HEIGHT >= 1");
  end

  state_t     state, state_nxt;
  logic [8:0] col, col_base, col_nxt;
  logic [2:0] bank, bank_base, bank_nxt;
  logic [2:0] filled, filled_base, filled_nxt;
  logic       accept, last;
  logic       frame_end;

`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
  localparam logic [8:0] LAST_ROW = 9'(IMG_HEIGHT - 1);
  logic [8:0] row, row_base, row_nxt;
`endif

  // frame_start restarts counters in the same cycle, so a coincident pixel lands at col 0 / bank 0.
  always_comb begin
    col_base    = frame_start ? '0 : col;
    bank_base   = frame_start ? '0 : bank;
    filled_base = frame_start ? '0 : filled;
    accept      = pix_valid && (frame_start || state != IDLE);
    last        = accept && (col_base == LAST_COL);
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
    row_base  = frame_start ? '0 : row;
    frame_end = last && (row_base == LAST_ROW);
`else
    frame_end = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) state_nxt = FILL;
    if (state_nxt == FILL && last && filled_base == 3'd4) state_nxt = STREAM;
    if (frame_end) state_nxt = IDLE;
  end

  always_comb begin
    col_nxt    = col_base;
    bank_nxt   = bank_base;
    filled_nxt = filled_base;
    if (accept) col_nxt = last ? '0 : col_base + 9'd1;
    if (last) begin
      bank_nxt = (bank_base == 3'd5) ? '0 : bank_base + 3'd1;
      if (frame_start || state == FILL) filled_nxt = filled_base + 3'd1;
    end
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
    row_nxt = row_base;
    if (last) row_nxt = frame_end ? '0 : row_base + 9'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      bank         <= '0;
      filled       <= '0;
      write_enable <= 1'b0;
      select       <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      line_done    <= 1'b0;
    end else begin
      col          <= col_nxt;
      bank         <= bank_nxt;
      filled       <= filled_nxt;
      write_enable <= accept;
      line_done    <= last;
      if (accept) begin
        select  <= bank_base;
        wr_addr <= col_base;
        wr_data <= pix_data;
      end
    end
  end

`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      row        <= row_nxt;
      frame_done <= frame_end;
    end
  end

  assign row_idx = row;
`endif

  assign lines_ready = (state == STREAM);

endmodule

// File: tb/tb_line_write_ctrl.sv
// Self-checking bench for line_write_ctrl (IMG_WIDTH=8): constant vector table, directed
// sequences and a randomized run against a pixel-count reference model.
module tb_line_write_ctrl;

  localparam int W = 8;
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
  localparam int H = 4;
`else
  localparam int H = 240;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       write_enable, line_done, lines_ready;
  logic [2:0] select;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
  logic [8:0] row_idx;
  logic       frame_done;
`endif

  line_write_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .write_enable(write_enable), .select(select),
    .wr_addr(wr_addr), .wr_data(wr_data), .line_done(line_done),
    .lines_ready(lines_ready)
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
    , .row_idx(row_idx), .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a frame is a stream of accepted pixels; everything follows from the count.
  bit m_active = 0;
  int m_n = 0;
  bit e_we, e_ld, e_lr, e_fd;
  int e_sel, e_addr, e_data, e_row;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit fs, input bit pv, input logic [7:0] d);
    e_we = 0; e_ld = 0; e_fd = 0;
    if (r) begin
      m_active = 0; m_n = 0; e_sel = 0; e_addr = 0; e_data = 0;
    end else begin
      if (fs) begin m_active = 1; m_n = 0; end
      if (pv && m_active) begin
        e_we   = 1;
        e_addr = m_n % W;
        e_sel  = (m_n / W) % 6;
        e_data = int'(d);
        e_ld   = (m_n % W) == W - 1;
        m_n++;
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
        if (m_n == W * H) begin e_fd = 1; m_active = 0; end
`endif
      end
    end
    e_lr  = m_active && (m_n >= 5 * W);
    e_row = m_active ? m_n / W : 0;
  endtask

  task automatic cycle(input bit r, input bit fs, input bit pv, input logic [7:0] d);
    reset = r; frame_start = fs; pix_valid = pv; pix_data = d;
    @(posedge clk);
    model(r, fs, pv, d);
    #1;
    chk("model_we", int'(write_enable), int'(e_we));
    chk("model_ld", int'(line_done), int'(e_ld));
    chk("model_lr", int'(lines_ready), int'(e_lr));
    chk("model_sel", int'(select), e_sel);
    chk("model_addr", int'(wr_addr), e_addr);
    chk("model_data", int'(wr_data), e_data);
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
    chk("model_row", int'(row_idx), e_row);
    chk("model_fd", int'(frame_done), int'(e_fd));
`endif
  endtask

  typedef struct {
    bit rst, fs, pv;
    logic [7:0] d;
    bit we;
    int sel, addr, data;
    bit ld, lr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int ld_cnt, k;
    bit pv, r, fs;

    tbl[0] = '{rst: 1, fs: 0, pv: 0, d: 8'h00, we: 0, sel: 0, addr: 0, data: 0, ld: 0, lr: 0};
    tbl[1] = '{rst: 0, fs: 1, pv: 0, d: 8'h00, we: 0, sel: 0, addr: 0, data: 0, ld: 0, lr: 0};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{rst: 0, fs: 0, pv: 1, d: 8'(16 + i), we: 1, sel: 0, addr: i,
                   data: 16 + i, ld: (i == 7), lr: 0};
    tbl[10] = '{rst: 0, fs: 0, pv: 0, d: 8'h00, we: 0, sel: 0, addr: 7, data: 8'h17, ld: 0, lr: 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst, tbl[i].fs, tbl[i].pv, tbl[i].d);
      chk("tbl_we", int'(write_enable), int'(tbl[i].we));
      chk("tbl_sel", int'(select), tbl[i].sel);
      chk("tbl_addr", int'(wr_addr), tbl[i].addr);
      chk("tbl_data", int'(wr_data), tbl[i].data);
      chk("tbl_ld", int'(line_done), int'(tbl[i].ld));
      chk("tbl_lr", int'(lines_ready), int'(tbl[i].lr));
    end

    // Six lines of continuous pixels, then a wrap back to bank 0.
    cycle(0, 1, 0, 8'h00);
    for (int p = 1; p <= 56; p++) begin
      cycle(0, 0, 1, 8'(p));
`ifdef LINE_WRITE_CTRL_ROW_COUNT_EN
      if (p == 32) begin
        chk("h4_fd", int'(frame_done), 1);
        chk("h4_ld", int'(line_done), 1);
      end
      if (p == 33) chk("h4_idle_we", int'(write_enable), 0);
`else
      if (p == 39) chk("lr_before", int'(lines_ready), 0);
      if (p == 40) begin
        chk("lr_rise", int'(lines_ready), 1);
        chk("lr_rise_ld", int'(line_done), 1);
        chk("lr_rise_sel", int'(select), 4);
      end
      if (p == 48) chk("bank5_sel", int'(select), 5);
      if (p == 49) begin
        chk("wrap_sel", int'(select), 0);
        chk("wrap_addr", int'(wr_addr), 0);
        chk("wrap_lr", int'(lines_ready), 1);
      end
`endif
    end

    // Restart mid-line 2: partial line discarded.
    cycle(0, 1, 0, 8'h00);
    for (int p = 0; p < 19; p++) cycle(0, 0, 1, 8'(p));
    cycle(0, 1, 0, 8'h00);
    chk("restart_lr", int'(lines_ready), 0);
    cycle(0, 0, 1, 8'h5A);
    chk("restart_we", int'(write_enable), 1);
    chk("restart_sel", int'(select), 0);
    chk("restart_addr", int'(wr_addr), 0);

    // pix_valid pattern 1,0,0,1 over 16 cycles.
    cycle(0, 1, 0, 8'h00);
    k = 0; ld_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      pv = (c % 4 == 0) || (c % 4 == 3);
      cycle(0, 0, pv, 8'(16 + k));
      chk("gap_we", int'(write_enable), int'(pv));
      if (pv) begin
        chk("gap_addr", int'(wr_addr), k);
        chk("gap_data", int'(wr_data), 16 + k);
        k++;
      end
      ld_cnt += int'(line_done);
    end
    chk("gap_ld_count", ld_cnt, 1);

    // pix_valid in IDLE is ignored.
    cycle(1, 0, 0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      cycle(0, 0, 1, 8'(c));
      chk("idle_we", int'(write_enable), 0);
      chk("idle_sel", int'(select), 0);
    end

    // Reset priority, then frame_start coincident with a pixel.
    cycle(1, 1, 1, 8'hAA);
    chk("rst_prio_we", int'(write_enable), 0);
    cycle(0, 0, 1, 8'hBB);
    chk("post_rst_we", int'(write_enable), 0);
    cycle(0, 1, 1, 8'hCC);
    chk("fs_pv_we", int'(write_enable), 1);
    chk("fs_pv_addr", int'(wr_addr), 0);
    chk("fs_pv_data", int'(wr_data), 8'hCC);
    cycle(0, 0, 1, 8'hDD);
    chk("fs_pv_next_addr", int'(wr_addr), 1);

    // Randomized traffic against the model.
    cycle(0, 1, 0, 8'h00);
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 499) == 0);
      fs = ($urandom_range(0, 149) == 0);
      pv = ($urandom_range(0, 2) != 0);
      cycle(r, fs, pv, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
